// File: rtl/alu_pkg.sv
// Shared definitions for the serial subtractor: default width, FSM state
// encoding and the signed saturation limits used by the optional
// saturating build (ALU_SERIAL_SUB_SAT_EN).
package alu_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  localparam logic [WIDTH_DEFAULT-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [WIDTH_DEFAULT-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/alu_serial_sub_full_adder_bit.sv
// One-bit full adder: the bit slice the serial subtractor reuses every
// BUSY cycle.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and carry of a single bit position
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/alu_serial_sub.sv
// Bit-serial signed subtractor Z = X - Y, one result bit per clock, LSB
// first, computed as X + ~Y + 1 through a single full-adder slice.
// Handshake: operands accepted only in IDLE; result and flags held in DONE
// until out_ready.
// Optional macro ALU_SERIAL_SUB_SAT_EN: on signed overflow Z saturates to the
// most-positive / most-negative value, and Sign/Zero/Parity follow the
// saturated Z.
module alu_serial_sub
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             Sign,
  output logic             Zero,
  output logic             Borrow,
  output logic             Parity,
  output logic             Overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef ALU_SERIAL_SUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX_W =
    (WIDTH == WIDTH_DEFAULT) ? WIDTH'(SAT_MAX) : {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN_W =
    (WIDTH == WIDTH_DEFAULT) ? WIDTH'(SAT_MIN) : {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // 1 when the vector holds an even number of ones
  function automatic logic parity_even(input logic [WIDTH-1:0] v);
    return ~(^v);
  endfunction

  alu_state_e       state_r;
  alu_state_e       state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] raw_r;
  logic             carry_r;

  logic             sum_s;
  logic             cout_s;
  logic             last_s;
  logic [WIDTH-1:0] raw_full_s;
  logic             ovf_s;
  logic             borrow_s;
  logic [WIDTH-1:0] z_fin_s;

  // The single bit slice: X[i] + ~Y[i] + carry
  full_adder_bit u_fa (
    .a    (x_r[cnt_r]),
    .b    (~y_r[cnt_r]),
    .cin  (carry_r),
    .s    (sum_s),
    .cout (cout_s)
  );

  assign in_ready = (state_r == IDLE);

  // Next-state logic of the IDLE/BUSY/DONE sequencer
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nx_s = BUSY;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == CNT_LAST) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register; reset wins over any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Result assembly: the bit finished this cycle merged into the partial
  // result, plus the signed-overflow and borrow judgement on the final word
  always_comb begin
    last_s             = (cnt_r == CNT_LAST);
    raw_full_s         = raw_r;
    raw_full_s[cnt_r]  = sum_s;
    ovf_s    = (x_r[WIDTH-1] != y_r[WIDTH-1]) && (raw_full_s[WIDTH-1] != x_r[WIDTH-1]);
    borrow_s = ~cout_s;
`ifdef ALU_SERIAL_SUB_SAT_EN
    if (ovf_s) begin
      z_fin_s = x_r[WIDTH-1] ? SAT_MIN_W : SAT_MAX_W;
    end else begin
      z_fin_s = raw_full_s;
    end
`else
    z_fin_s = raw_full_s;
`endif
  end

  // Datapath: operand capture, per-bit accumulation and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r       <= {WIDTH{1'b0}};
      y_r       <= {WIDTH{1'b0}};
      raw_r     <= {WIDTH{1'b0}};
      carry_r   <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      Z         <= {WIDTH{1'b0}};
      Sign      <= 1'b0;
      Zero      <= 1'b0;
      Borrow    <= 1'b0;
      Parity    <= 1'b0;
      Overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            x_r     <= X;
            y_r     <= Y;
            cnt_r   <= {CNT_W{1'b0}};
            carry_r <= 1'b1;
          end
        end
        BUSY: begin
          raw_r   <= raw_full_s;
          carry_r <= cout_s;
          if (last_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            Z         <= z_fin_s;
            Sign      <= z_fin_s[WIDTH-1];
            Zero      <= ~(|z_fin_s);
            Parity    <= parity_even(z_fin_s);
            Borrow    <= borrow_s;
            Overflow  <= ovf_s;
            out_valid <= 1'b1;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_sub.sv
// Directed bench for alu_serial_sub (WIDTH=16): vector table of differences
// with hand-computed results/flags, plus stall, mid-operation reset and
// reset-in-DONE sequences. Honours ALU_SERIAL_SUB_SAT_EN for expectations.
module tb_alu_serial_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_s;
  logic [15:0] y_s;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z_s;
  logic        sign_s, zero_s, borrow_s, parity_s, ovf_s;

  int tests = 0;
  int fails = 0;

  alu_serial_sub #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .X(x_s), .Y(y_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .Z(z_s), .Sign(sign_s), .Zero(zero_s), .Borrow(borrow_s),
    .Parity(parity_s), .Overflow(ovf_s)
  );

  always #5 clk = ~clk;

  // flags packed as {Sign, Zero, Borrow, Parity, Overflow}
  typedef struct {
    string       name;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [4:0]  flags;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [4:0] flags_now();
    return {sign_s, zero_s, borrow_s, parity_s, ovf_s};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge, then count edges until out_valid
  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        output int lat, output bit ok);
    x_s = x;
    y_s = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
      lat++;
    end
  endtask

  int lat;
  bit ok;
  logic [15:0] held_z;
  logic [4:0]  held_f;
  int seen_valid;

  initial begin
    vecs[0] = '{"5-3",        16'h0005, 16'h0003, 16'h0002, 5'b00000};
    vecs[1] = '{"3-5",        16'h0003, 16'h0005, 16'hFFFE, 5'b10100};
`ifdef ALU_SERIAL_SUB_SAT_EN
    vecs[2] = '{"8000-0001",  16'h8000, 16'h0001, 16'h8000, 5'b10001};
    vecs[3] = '{"7FFF-FFFF",  16'h7FFF, 16'hFFFF, 16'h7FFF, 5'b00101};
`else
    vecs[2] = '{"8000-0001",  16'h8000, 16'h0001, 16'h7FFF, 5'b00001};
    vecs[3] = '{"7FFF-FFFF",  16'h7FFF, 16'hFFFF, 16'h8000, 5'b10101};
`endif
    vecs[4] = '{"1234-1234",  16'h1234, 16'h1234, 16'h0000, 5'b01010};
    vecs[5] = '{"0-1",        16'h0000, 16'h0001, 16'hFFFF, 5'b10110};
    vecs[6] = '{"00FF-000F",  16'h00FF, 16'h000F, 16'h00F0, 5'b00010};
    vecs[7] = '{"0-0",        16'h0000, 16'h0000, 16'h0000, 5'b01010};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x_s = 16'h0000;
    y_s = 16'h0000;
    tick();
    tick();
    check("reset_z", {16'h0000, z_s}, 32'h0000_0000);
    check("reset_flags", {27'd0, flags_now()}, 32'h0000_0000);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // Table: result, flags and latency for each vector
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].x, vecs[i].y, lat, ok);
      check({vecs[i].name, "_done"}, {31'd0, ok}, 32'd1);
      check({vecs[i].name, "_latency"}, lat, 32'd16);
      check({vecs[i].name, "_z"}, {16'h0000, z_s}, {16'h0000, vecs[i].z});
      check({vecs[i].name, "_flags"}, {27'd0, flags_now()}, {27'd0, vecs[i].flags});
      tick();
      check({vecs[i].name, "_back_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    end

    // Stall in DONE for 5 cycles with in_valid pulses that must be ignored
    out_ready = 1'b0;
    run_op(16'h0005, 16'h0003, lat, ok);
    check("stall_done", {31'd0, ok}, 32'd1);
    held_z = z_s;
    held_f = flags_now();
    check("stall_z", {16'h0000, held_z}, 32'h0000_0002);
    for (int c = 0; c < 5; c++) begin
      x_s = 16'hAAAA;
      y_s = 16'h1111;
      in_valid = c[0];
      tick();
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_z_stable", {16'h0000, z_s}, {16'h0000, held_z});
      check("stall_flags_stable", {27'd0, flags_now()}, {27'd0, held_f});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("stall_release", {30'd0, out_valid, in_ready}, 32'd1);
    tick();
    check("stall_no_accept", {31'd0, in_ready}, 32'd1);

    // Reset at BUSY cycle 8: abort, no out_valid afterwards
    x_s = 16'h0005;
    y_s = 16'h0003;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("busy_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("busy_rst_out_valid", {31'd0, out_valid}, 32'd0);
    seen_valid = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (out_valid) seen_valid++;
    end
    check("busy_rst_no_stale", seen_valid, 32'd0);

    // Fresh operation after the abort
    run_op(16'h00FF, 16'h000F, lat, ok);
    check("post_rst_latency", lat, 32'd16);
    check("post_rst_z", {16'h0000, z_s}, 32'h0000_00F0);
    tick();

    // Reset while held in DONE, with out_ready also asserted
    out_ready = 1'b0;
    run_op(16'h0003, 16'h0005, lat, ok);
    check("done_rst_reach", {31'd0, ok}, 32'd1);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    check("done_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("done_rst_z_cleared", {16'h0000, z_s}, 32'h0000_0000);
    check("done_rst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
